// File: rtl/dmem_responder_if.sv
// CPU memory-stage to data-memory bus: load/store requests in, load data and store-buffer occupancy out.
interface dmem_responder_if #(
    parameter int SB_DEPTH = 4
) ();
    logic [31:0]               wr_addr_s;
    logic [31:0]               data2_s;
    logic                      lw_en_s;
    logic                      sw_en_s;
    logic [31:0]               data_mem;
    logic                      rd_valid;
    logic [$clog2(SB_DEPTH):0] sb_count;

    modport master (
        output wr_addr_s, data2_s, lw_en_s, sw_en_s,
        input  data_mem, rd_valid, sb_count
    );

    modport slave (
        input  wr_addr_s, data2_s, lw_en_s, sw_en_s,
        output data_mem, rd_valid, sb_count
    );
endinterface

// File: rtl/dmem_responder.sv
// Single-port data memory with 1-cycle loads; define DMEM_STORE_BUFFER_EN to add a forwarding store buffer
// that drains into the array on cycles without a load.
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int SB_DEPTH    = 4
) (
    input logic             clk,
    input logic             rst,
    dmem_responder_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int CNT_W = $clog2(SB_DEPTH) + 1;

    logic [31:0]      mem [DEPTH_WORDS];
    logic [IDX_W-1:0] req_idx;
    logic             load;
    logic             mem_we;
    logic [IDX_W-1:0] mem_widx;
    logic [31:0]      mem_wdata;
    logic [31:0]      load_word;
    logic [CNT_W-1:0] count;
    logic             rd_valid_q;
    logic [31:0]      data_q;
    logic             unused_addr;

    assign req_idx     = bus.wr_addr_s[IDX_W+1:2];
    assign unused_addr = ^{bus.wr_addr_s[31:IDX_W+2], bus.wr_addr_s[1:0]};
    // A simultaneous load and store is a store only.
    assign load        = bus.lw_en_s & ~bus.sw_en_s;

    // NOTE: storage arrays carry no reset so they map onto RAM; only control state is cleared.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_widx] <= mem_wdata;
    end

`ifdef DMEM_STORE_BUFFER_EN
    localparam int PTR_W = $clog2(SB_DEPTH);

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic [31:0]      data;
    } sb_entry_t;

    sb_entry_t         sb_mem [SB_DEPTH];
    logic [SB_DEPTH-1:0] sb_valid;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  slot;
    logic              push;
    logic              pop;
    logic              full;
    logic              fwd_hit;
    logic [31:0]       fwd_data;

    assign full = (count == CNT_W'(SB_DEPTH));
    assign push = bus.sw_en_s;
    // A store into a full buffer forces the drain even when lw_en_s is also high.
    assign pop  = (count != '0) && (!bus.lw_en_s || (push && full));

    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        slot     = rd_ptr;
        // Walk oldest to youngest so the last match wins.
        for (int k = 0; k < SB_DEPTH; k++) begin
            slot = rd_ptr + PTR_W'(k);
            if (sb_valid[slot] && (sb_mem[slot].idx == req_idx)) begin
                fwd_hit  = 1'b1;
                fwd_data = sb_mem[slot].data;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            sb_valid <= '0;
        end else begin
            if (pop) begin
                sb_valid[rd_ptr] <= 1'b0;
                rd_ptr           <= rd_ptr + 1'b1;
            end
            if (push) begin
                sb_valid[wr_ptr] <= 1'b1;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) sb_mem[wr_ptr] <= '{idx: req_idx, data: bus.data2_s};
    end

    assign mem_we    = pop;
    assign mem_widx  = sb_mem[rd_ptr].idx;
    assign mem_wdata = sb_mem[rd_ptr].data;
    assign load_word = fwd_hit ? fwd_data : mem[req_idx];
`else
    assign count     = '0;
    assign mem_we    = bus.sw_en_s;
    assign mem_widx  = req_idx;
    assign mem_wdata = bus.data2_s;
    assign load_word = mem[req_idx];
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_valid_q <= 1'b0;
            data_q     <= '0;
        end else begin
            rd_valid_q <= load;
            if (load) data_q <= load_word;
        end
    end

    assign bus.rd_valid = rd_valid_q;
    assign bus.data_mem = data_q;
    assign bus.sb_count = count;
endmodule
